// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state encoding, flag indices and 7-segment helpers
// Used by alu_bcd_display_unit and bcd_seg_decoder.
package alu_pkg;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_NOT
   } op_t;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_CONV = 2'd2;
   localparam state_t ST_DONE = 2'd3;
   localparam int FLAG_C = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   function automatic int pow10(input int n);
      int p;
      p = 1;
      for (int i = 0; i < n; i++) p *= 10;
      return p;
   endfunction
   // active-low {g..a}; non-decimal codes show blank
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return SEG_BLANK;
      endcase
   endfunction
endpackage

// File: rtl/alu_bcd_display_unit_seg.sv
// bcd_seg_decoder: one BCD digit plus blank enable to active-low 7-segment pattern
// Ports: i_bcd (digit 0..9), i_blank (force all segments off), o_seg ({g..a}, active-low).
module bcd_seg_decoder
   import alu_pkg::*;
(
   input  logic [3:0] i_bcd,
   input  logic       i_blank,
   output logic [6:0] o_seg
);
   assign o_seg = i_blank ? SEG_BLANK : seg7(i_bcd);
endmodule

// File: rtl/alu_bcd_display_unit.sv
// alu_bcd_display_unit: registered ALU with C/N/Z/V flags and double-dabble 7-segment display
// Ports: clk, reset (async, active-high); in_valid/in_ready handshake with a, b, op;
//        out_valid pulse, result, flags {C,N,Z,V}, seg_digits (active-low, digit i at [7i+6:7i]),
//        flag_leds (flags as shown with the current display).
// Build option: ALU_SIGNED_DISPLAY_EN shows negative results as '-' plus magnitude.
module alu_bcd_display_unit
   import alu_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int NUM_DIGITS = 3
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        a,
   input  logic [WIDTH-1:0]        b,
   input  logic [2:0]              op,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        result,
   output logic [3:0]              flags,
   output logic [7*NUM_DIGITS-1:0] seg_digits,
   output logic [3:0]              flag_leds
);
   localparam int MSB = WIDTH - 1;
   localparam int BW  = 4 * NUM_DIGITS;
   localparam int CW  = $clog2(WIDTH);

   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("WIDTH must be within 2..16");
   end
   if (pow10(NUM_DIGITS) <= (1 << WIDTH) - 1) begin : g_bad_digits
      $error("NUM_DIGITS too small for WIDTH");
   end
`ifdef ALU_SIGNED_DISPLAY_EN
   if (pow10(NUM_DIGITS - 1) <= (1 << (WIDTH - 1))) begin : g_bad_signed
      $error("NUM_DIGITS-1 digits cannot hold the signed magnitude");
   end
`endif

   state_t                  r_state;
   op_t                     r_op;
   logic [WIDTH-1:0]        r_a, r_b, r_result, r_bin;
   logic [3:0]              r_flags, r_leds;
   logic [BW-1:0]           r_bcd;
   logic [CW-1:0]           r_cnt;
   logic [7*NUM_DIGITS-1:0] r_seg;
   logic                    r_out_valid;

   logic [WIDTH:0]          w_ext;
   logic [WIDTH-1:0]        w_res, w_bin_init;
   logic                    w_v;
   logic [3:0]              w_flags;
   logic [BW-1:0]           w_bcd_adj;
   logic [7*NUM_DIGITS-1:0] w_seg, w_disp;

   // bit WIDTH of w_ext is the carry/borrow/shifted-out bit for every opcode
   always_comb begin
      w_ext = '0;
      w_v   = 1'b0;
      case (r_op)
         OP_ADD: begin
            w_ext = {1'b0, r_a} + {1'b0, r_b};
            w_v   = (r_a[MSB] == r_b[MSB]) && (w_ext[MSB] != r_a[MSB]);
         end
         OP_SUB: begin
            w_ext = {1'b0, r_a} - {1'b0, r_b};
            w_v   = (r_a[MSB] != r_b[MSB]) && (w_ext[MSB] != r_a[MSB]);
         end
         OP_AND:  w_ext = {1'b0, r_a & r_b};
         OP_OR:   w_ext = {1'b0, r_a | r_b};
         OP_XOR:  w_ext = {1'b0, r_a ^ r_b};
         OP_SHL:  w_ext = {r_a, 1'b0};
         OP_SHR:  w_ext = {r_a[0], 1'b0, r_a[MSB:1]};
         default: w_ext = {1'b0, ~r_a};
      endcase
   end

   assign w_res   = w_ext[MSB:0];
   assign w_flags = {w_ext[WIDTH], w_res[MSB], w_res == '0, w_v};

`ifdef ALU_SIGNED_DISPLAY_EN
   // two's-complement magnitude; the most negative value maps onto itself, read as unsigned
   assign w_bin_init = w_res[MSB] ? -w_res : w_res;
`else
   assign w_bin_init = w_res;
`endif

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (r_bcd[4*i +: 4] > 4'd4) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
   end

   // a digit blanks when it and every digit above it are zero; digit 0 never blanks
   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
      bcd_seg_decoder u_dec (
         .i_bcd   (r_bcd[4*d +: 4]),
         .i_blank ((d != 0) && (r_bcd[BW-1:4*d] == '0)),
         .o_seg   (w_seg[7*d +: 7])
      );
   end

`ifdef ALU_SIGNED_DISPLAY_EN
   assign w_disp = r_flags[FLAG_N] ? {SEG_MINUS, w_seg[7*NUM_DIGITS-8:0]} : w_seg;
`else
   assign w_disp = w_seg;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_ADD;
         r_a         <= '0;
         r_b         <= '0;
         r_result    <= '0;
         r_flags     <= 4'b0010;
         r_bin       <= '0;
         r_bcd       <= '0;
         r_cnt       <= '0;
         r_seg       <= {NUM_DIGITS{SEG_BLANK}};
         r_leds      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE: if (in_valid) begin
               r_a     <= a;
               r_b     <= b;
               r_op    <= op_t'(op);
               r_state <= ST_CALC;
            end
            ST_CALC: begin
               r_result <= w_res;
               r_flags  <= w_flags;
               r_bin    <= w_bin_init;
               r_bcd    <= '0;
               r_cnt    <= '0;
               r_state  <= ST_CONV;
            end
            ST_CONV: begin
               r_bcd <= {w_bcd_adj[BW-2:0], r_bin[MSB]};
               r_bin <= {r_bin[MSB-1:0], 1'b0};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) r_state <= ST_DONE;
            end
            default: begin
               r_seg       <= w_disp;
               r_leds      <= r_flags;
               r_out_valid <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = (r_state == ST_IDLE);
   assign out_valid  = r_out_valid;
   assign result     = r_result;
   assign flags      = r_flags;
   assign seg_digits = r_seg;
   assign flag_leds  = r_leds;
endmodule

// File: tb/tb_alu_bcd_display_unit.sv
// tb_alu_bcd_display_unit: scoreboard bench for alu_bcd_display_unit (default unsigned display build)
module tb_alu_bcd_display_unit;
   localparam int W  = 8;
   localparam int ND = 3;
   localparam logic [7*ND-1:0] BLANKS = {ND{7'h7F}};

   typedef struct {
      int              due;
      logic [3:0]      flags;
      logic [7*ND-1:0] seg;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready, out_valid;
   logic [W-1:0]    a = '0, b = '0, result;
   logic [2:0]      op = '0;
   logic [3:0]      flags, flag_leds;
   logic [7*ND-1:0] seg_digits;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, free_at = 0, pend_at = -1, k;
   int pend_res, m_res = 0;
   logic [3:0] pend_flags, m_flags = 4'b0010, m_leds = '0;
   logic [7*ND-1:0] m_disp = BLANKS;
   exp_t q[$];

   alu_bcd_display_unit #(.WIDTH(W), .NUM_DIGITS(ND)) dut (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .result(result),
      .flags(flags), .seg_digits(seg_digits), .flag_leds(flag_leds)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         default: return 7'h10;
      endcase
   endfunction

   function automatic void ref_model(input int ia, input int ib, input int iop,
                                     output int r, output logic [3:0] f, output logic [7*ND-1:0] s);
      int m, h, sa, sb, sr, p;
      logic c, v;
      m = 1 << W;
      h = 1 << (W - 1);
      sa = (ia >= h) ? ia - m : ia;
      sb = (ib >= h) ? ib - m : ib;
      c = 1'b0;
      v = 1'b0;
      case (iop)
         0: begin r = (ia + ib) % m; c = (ia + ib) >= m; sr = sa + sb; v = (sr >= h) || (sr < -h); end
         1: begin r = (ia - ib + m) % m; c = ia < ib; sr = sa - sb; v = (sr >= h) || (sr < -h); end
         2: r = ia & ib;
         3: r = ia | ib;
         4: r = ia ^ ib;
         5: begin r = (ia * 2) % m; c = ia >= h; end
         6: begin r = ia / 2; c = (ia % 2) == 1; end
         default: r = m - 1 - ia;
      endcase
      f = {c, r >= h, r == 0, v};
      p = 1;
      for (int i = 0; i < ND; i++) begin
         s[7*i +: 7] = (i > 0 && r < p) ? 7'h7F : seg_of((r / p) % 10);
         p *= 10;
      end
   endfunction

   // acceptance model: a transfer happens whenever in_valid meets an idle unit
   always @(posedge clk) begin
      int r;
      logic [3:0] f;
      logic [7*ND-1:0] s;
      if (!rst && in_valid && cyc >= free_at) begin
         ref_model(int'(a), int'(b), int'(op), r, f, s);
         pend_res   = r;
         pend_flags = f;
         pend_at    = cyc + 2;
         q.push_back('{due: cyc + W + 3, flags: f, seg: s});
         free_at    = cyc + W + 3;
      end
      cyc++;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         free_at = 0;
         pend_at = -1;
         m_res   = 0;
         m_flags = 4'b0010;
         m_disp  = BLANKS;
         m_leds  = '0;
      end
      if (pend_at == cyc) begin
         m_res   = pend_res;
         m_flags = pend_flags;
      end
      if (out_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_valid at cycle %0d: got 1 expected 0", cyc);
         end else begin
            e = q.pop_front();
            chk("latency", cyc, e.due);
            m_disp = e.seg;
            m_leds = e.flags;
         end
      end else if (q.size() > 0 && cyc > q[0].due) begin
         e = q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL out_valid at cycle %0d: got 0 expected 1 by cycle %0d", cyc, e.due);
      end
      chk("in_ready", int'(in_ready), int'(rst || cyc >= free_at));
      chk("result", int'(result), m_res);
      chk("flags", int'(flags), int'(m_flags));
      chk("seg_digits", int'(seg_digits), int'(m_disp));
      chk("flag_leds", int'(flag_leds), int'(m_leds));
   end

   task automatic send(input int ta, input int tb, input int top, output int acc);
      @(negedge clk);
      while (cyc < free_at) @(negedge clk);
      in_valid = 1'b1;
      a = W'(ta);
      b = W'(tb);
      op = 3'(top);
      acc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      op = 3'($urandom);
   endtask

   initial begin
      int da[10] = '{200, 5, 127, 'h55, 'h81, 'h81, 'hFF, 'h0F, 'h0F, 0};
      int db[10] = '{100, 9, 1, 'h55, 0, 0, 0, 'h3C, 'h30, 0};
      int dop[10] = '{0, 1, 0, 4, 5, 6, 7, 2, 3, 0};
      // in_valid is already high while reset releases; only the edge after release may transfer
      in_valid = 1'b1;
      a = 8'd3;
      b = 8'd4;
      op = 3'd0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) send(da[i], db[i], dop[i], k);
      // held in_valid with changing operands while busy
      @(negedge clk);
      while (cyc < free_at) @(negedge clk);
      for (int i = 0; i < 3 * (W + 3) + 2; i++) begin
         in_valid = 1'b1;
         a = W'($urandom);
         b = W'($urandom);
         op = 3'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      // reset during the third CONVERT cycle abandons the conversion
      send(200, 100, 0, k);
      while (cyc < k + 3) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #3 rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), k);
      end
      repeat (W + 8) @(negedge clk);
      chk("drain", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/alu_bcd_display_unit.md
Name: alu_bcd_display_unit

Overview:
- Parametrised, sequential successor to the team's 4-bit combinational ALU-plus-display block.
- Accepts one operand pair and opcode per ready/valid transaction and registers the result and four flags (C, N, Z, V).
- Converts the result to decimal with a multi-cycle shift-add-3 (double-dabble) FSM, then drives NUM_DIGITS active-low 7-segment digits plus a flag LED bank.
- Sits between the board switch/button front end and the physical displays.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..16).
- NUM_DIGITS, 3, decimal digits driven; must satisfy 10^NUM_DIGITS > 2^WIDTH - 1.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/opcode presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  opcode.
- out_valid  out  1  one-cycle pulse when result, flags and displays have updated.
- result  out  WIDTH  registered ALU result.
- flags  out  4  {C,N,Z,V}, registered.
- seg_digits  out  7*NUM_DIGITS  digit i at bits [7i+6:7i], segments {g..a}, active-low.
- flag_leds  out  4  mirrors flags; updates with the display.

Behaviour:
- Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL by 1, 110 SHR logical by 1, 111 NOT A.
- Flags:
  - ADD: C = carry out.
  - SUB: C = borrow, i.e. 1 iff A<B unsigned.
  - SHL/SHR: C = bit shifted out.
  - Logic ops: C=0, V=0.
  - V = signed overflow for ADD/SUB.
  - N = result[WIDTH-1]; Z = (result==0).
  - All results are truncated to WIDTH bits.
- Handshake: a transfer occurs on a clk edge with in_valid && in_ready. a, b and op are sampled only at that edge; later changes are ignored. in_valid while busy is ignored, not queued.
- FSM states IDLE -> CALC -> CONVERT -> DONE -> IDLE:
  - IDLE: in_ready=1.
  - CALC: 1 cycle; result and flags registered here, visible on result/flags from the next cycle.
  - CONVERT: exactly WIDTH cycles of shift-add-3.
  - DONE: 1 cycle; seg_digits and flag_leds load, out_valid=1.
- Latency: accept edge to out_valid = WIDTH+2 cycles. Back-to-back throughput is one transaction per WIDTH+3 cycles.
- Display hold: seg_digits and flag_leds keep their last value until the next DONE. result/flags change at CALC, ahead of the display.
- Leading-zero blanking: digits above the most significant nonzero digit show blank (7'h7F). Digit 0 always shows, so a value of 0 displays "0".
- Reset (async, any state, including mid-CONVERT):
  - state=IDLE, in_ready=1, out_valid=0, result=0, flags=4'b0010 (Z set).
  - flag_leds=0.
  - all seg_digits blank (7'h7F).
  - conversion is abandoned with no partial display update.
- Deasserting reset in the same cycle as in_valid: no transfer on that edge, because the first sampling edge follows release.

Optional Feature:
- Macro: ALU_SIGNED_DISPLAY_EN.
- Defined:
  - If N=1, the converter operates on the two's-complement magnitude.
  - The highest digit position shows '-' (7'b0111111) instead of a numeral.
  - NUM_DIGITS must then allow magnitude 2^(WIDTH-1) in NUM_DIGITS-1 digits, else elaboration error.
  - The most negative value displays its correct magnitude, e.g. WIDTH=8: -128.
- Undefined: result is always displayed as unsigned decimal and N affects only flags/flag_leds.

Decomposition:
- Shared package alu_pkg:
  - opcode enum (OP_ADD..OP_NOT).
  - FSM state typedef.
  - flag index constants (FLAG_C=3, FLAG_N=2, FLAG_Z=1, FLAG_V=0).
  - SEG_BLANK and SEG_MINUS constants.
  - 4-bit-to-7-segment function.
- One natural sub-module: bcd_seg_decoder (one BCD digit plus blank enable to 7 active-low segments), instantiated NUM_DIGITS times.
- The ALU datapath and the converter stay inline.

Test Plan:
- Reset: after reset, in_ready=1, out_valid=0, flags=0010, flag_leds=0, every seg_digits group=7'h7F. Assert reset on cycle 3 of CONVERT -> same values, no out_valid.
- ADD, WIDTH=8: a=200, b=100, op=000 -> result=44, C=1, V=0. out_valid exactly 10 cycles after the accept edge. Digits "_44", top digit blank.
- SUB: a=5, b=9 -> result=252, C=1, N=1.
  - Unsigned build: display "252".
  - ALU_SIGNED_DISPLAY_EN build: display "-4", i.e. digit2=minus, digit1 blank, digit0=4.
- Overflow/zero: a=127, b=1 ADD -> result=128, V=1, N=1. a=0x55 XOR b=0x55 -> result=0, Z=1, display "__0".
- Shifts: a=0x81 SHL -> 0x02, C=1. a=0x81 SHR -> 0x40, C=1. NOT a=0xFF -> 0, Z=1, C=0.
- Handshake: hold in_valid high with changing a/b during busy -> only the first sample is processed, in_ready low throughout. The second transaction is accepted on the first IDLE cycle, and the display holds old digits until its DONE.
